// File: rtl/psola_window_scheduler.sv
// PSOLA window scheduler: write pointer, ping-pong toggle, tau selection,
// engine start/done handshake and overrun accounting.
module psola_window_scheduler #(
    parameter int WINDOW_SIZE   = 2048,
    parameter int MIN_TAU       = 16,
    parameter int MAX_TAU       = 1024,
    parameter int STALE_WINDOWS = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_valid_in,
    input  logic [10:0]                    tau_in,
    input  logic                           tau_valid_in,
    input  logic                           engine_ready_in,
    input  logic                           engine_done_in,
    output logic                           engine_start_out,
    output logic [10:0]                    engine_tau_out,
    output logic [$clog2(WINDOW_SIZE)-1:0] sample_addr_out,
    output logic                           window_toggle_out,
    output logic                           window_boundary_out,
    output logic                           bypass_out,
    output logic                           overrun_out,
    output logic [7:0]                     overrun_count_out,
    output logic                           busy_out
);

    localparam int AW = $clog2(WINDOW_SIZE);
    localparam int SW = $clog2(STALE_WINDOWS + 2);
    localparam logic [AW-1:0] ADDR_LAST = AW'(WINDOW_SIZE - 1);
    localparam logic [10:0]   TAU_LO    = 11'(MIN_TAU);
    localparam logic [10:0]   TAU_HI    = 11'(MAX_TAU);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_WINDOWS);

    typedef enum logic [1:0] {
        S_FILL_FIRST,
        S_WAIT,
        S_ISSUE,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          toggle_q, toggle_d;
    logic          boundary_q, boundary_d;
    logic          bypass_q, bypass_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    ovr_cnt_q, ovr_cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic [10:0]   pend_tau_q, pend_tau_d;
    logic [10:0]   last_tau_q, last_tau_d;
    logic [SW-1:0] stale_q, stale_d;
    logic [10:0]   job_tau_q, job_tau_d;

    logic          bnd;
    logic          tau_ok;
    logic          run_ovr;
    logic          sel_job;
    logic [10:0]   sel_tau;

    // Window boundary, tau acceptance and the job choice a boundary would make.
    always_comb begin
        bnd     = sample_valid_in && (addr_q == ADDR_LAST);
        tau_ok  = tau_valid_in && (tau_in >= TAU_LO) && (tau_in <= TAU_HI);
        run_ovr = bnd && (state_q == S_RUN) && !engine_done_in;
        sel_job = 1'b0;
        sel_tau = job_tau_q;
        if (pend_vld_q) begin
            sel_job = 1'b1;
            sel_tau = pend_tau_q;
        end else if (stale_q < STALE_MAX) begin
            sel_job = 1'b1;
            sel_tau = last_tau_q;
        end
    end

    // Next-state: pointer, tau bookkeeping, FSM and overrun counter.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        toggle_d   = toggle_q;
        boundary_d = 1'b0;
        bypass_d   = bypass_q;
        overrun_d  = 1'b0;
        ovr_cnt_d  = ovr_cnt_q;
        pend_vld_d = pend_vld_q;
        pend_tau_d = pend_tau_q;
        last_tau_d = last_tau_q;
        stale_d    = stale_q;
        job_tau_d  = job_tau_q;

        if (sample_valid_in) begin
            addr_d = addr_q + 1'b1;
        end

        if (bnd) begin
            toggle_d   = ~toggle_q;
            boundary_d = 1'b1;
            // Tau is consumed at every boundary, even when the job is skipped.
            if (pend_vld_q) begin
                last_tau_d = pend_tau_q;
                stale_d    = '0;
                pend_vld_d = 1'b0;
            end else if (stale_q < STALE_MAX) begin
                stale_d = stale_q + 1'b1;
            end
            if (run_ovr) begin
                bypass_d = 1'b1;
            end else begin
                bypass_d = ~sel_job;
                if (sel_job) begin
                    job_tau_d = sel_tau;
                    state_d   = S_ISSUE;
                end else begin
                    state_d   = S_WAIT;
                end
            end
            overrun_d = run_ovr || (state_q == S_ISSUE);
        end else begin
            unique case (state_q)
                S_ISSUE: if (engine_ready_in) state_d = S_RUN;
                S_RUN:   if (engine_done_in)  state_d = S_WAIT;
                default: ;
            endcase
        end

        // A report on the boundary cycle lands after selection used the old one.
        if (tau_ok) begin
            pend_tau_d = tau_in;
            pend_vld_d = 1'b1;
        end

        if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_FILL_FIRST;
            addr_q     <= '0;
            toggle_q   <= 1'b0;
            boundary_q <= 1'b0;
            bypass_q   <= 1'b1;
            overrun_q  <= 1'b0;
            ovr_cnt_q  <= '0;
            pend_vld_q <= 1'b0;
            pend_tau_q <= '0;
            last_tau_q <= '0;
            stale_q    <= STALE_MAX;
            job_tau_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            toggle_q   <= toggle_d;
            boundary_q <= boundary_d;
            bypass_q   <= bypass_d;
            overrun_q  <= overrun_d;
            ovr_cnt_q  <= ovr_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_tau_q <= pend_tau_d;
            last_tau_q <= last_tau_d;
            stale_q    <= stale_d;
            job_tau_q  <= job_tau_d;
        end
    end

    assign engine_start_out    = (state_q == S_ISSUE);
    assign busy_out            = (state_q == S_ISSUE) || (state_q == S_RUN);
    assign engine_tau_out      = job_tau_q;
    assign sample_addr_out     = addr_q;
    assign window_toggle_out   = toggle_q;
    assign window_boundary_out = boundary_q;
    assign bypass_out          = bypass_q;
    assign overrun_out         = overrun_q;
    assign overrun_count_out   = ovr_cnt_q;

endmodule

// File: tb/tb_psola_window_scheduler.sv
// Testbench for psola_window_scheduler with a small window so that
// counter saturation fits in a short run.
module tb_psola_window_scheduler;

    localparam int W  = 128;
    localparam int AW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_valid;
    logic [10:0]   tau_in;
    logic          tau_valid;
    logic          engine_ready;
    logic          engine_done;
    logic          engine_start;
    logic [10:0]   engine_tau;
    logic [AW-1:0] addr;
    logic          toggle;
    logic          boundary;
    logic          bypass;
    logic          overrun;
    logic [7:0]    ovr_cnt;
    logic          busy;

    typedef struct {
        logic        byp;
        logic        st;
        logic [10:0] tau;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_start = 0;
    int   n_ovr = 0;

    psola_window_scheduler #(
        .WINDOW_SIZE(W), .MIN_TAU(16), .MAX_TAU(64), .STALE_WINDOWS(2)
    ) dut (
        .clk_in(clk), .rst_in(rst_n),
        .sample_valid_in(sample_valid), .tau_in(tau_in),
        .tau_valid_in(tau_valid), .engine_ready_in(engine_ready),
        .engine_done_in(engine_done), .engine_start_out(engine_start),
        .engine_tau_out(engine_tau), .sample_addr_out(addr),
        .window_toggle_out(toggle), .window_boundary_out(boundary),
        .bypass_out(bypass), .overrun_out(overrun),
        .overrun_count_out(ovr_cnt), .busy_out(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (engine_start) n_start <= n_start + 1;
        if (overrun) n_ovr <= n_ovr + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 0; tau_valid = 0; tau_in = '0;
        engine_ready = 0; engine_done = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic feed(input int n, input logic tv, input logic [10:0] tval,
                        input logic dn);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            if (i == n - 1) begin
                tau_valid = tv; tau_in = tval; engine_done = dn;
            end
            step();
        end
        sample_valid = 0; tau_valid = 0; engine_done = 0;
    endtask

    task automatic report(input logic [10:0] t);
        tau_valid = 1'b1; tau_in = t;
        step();
        tau_valid = 1'b0;
    endtask

    task automatic pulse_done();
        engine_done = 1'b1;
        step();
        engine_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        engine_ready = 1'b1;
        report(11'd40);
        feed(W, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", addr); end
        n_cmp++; if (bypass !== 1'b1) begin n_bad++; $display("FAIL reset_bypass got %0b want 1", bypass); end
        n_cmp++; if (engine_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got %0b want 0", engine_start); end
        n_cmp++; if (toggle !== 1'b0) begin n_bad++; $display("FAIL reset_toggle got %0b want 0", toggle); end
        n_cmp++; if (engine_tau !== 11'd0) begin n_bad++; $display("FAIL reset_tau got %0d want 0", engine_tau); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (ovr_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", ovr_cnt); end
    endtask

    task automatic test_first_window();
        do_reset();
        feed(W - 1, 0, 0, 0);
        step();
        n_cmp++; if (addr !== AW'(W - 1)) begin n_bad++; $display("FAIL addr_hold got %0d want %0d", addr, W - 1); end
        n_cmp++; if (boundary !== 1'b0) begin n_bad++; $display("FAIL early_bnd got %0b want 0", boundary); end
        sb.push_back('{byp: 1'b1, st: 1'b0, tau: 11'd0});
        feed(1, 0, 0, 0);
        n_cmp++; if (boundary !== 1'b1) begin n_bad++; $display("FAIL first_bnd got %0b want 1", boundary); end
        n_cmp++; if (toggle !== 1'b1) begin n_bad++; $display("FAIL first_toggle got %0b want 1", toggle); end
        n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL first_wrap got %0d want 0", addr); end
        begin
            exp_t e = sb.pop_front();
            n_cmp++; if (bypass !== e.byp) begin n_bad++; $display("FAIL first_bypass got %0b want %0b", bypass, e.byp); end
            n_cmp++; if (engine_start !== e.st) begin n_bad++; $display("FAIL first_start got %0b want %0b", engine_start, e.st); end
        end
        step();
        n_cmp++; if (boundary !== 1'b0) begin n_bad++; $display("FAIL bnd_pulse got %0b want 0", boundary); end
    endtask

    task automatic test_job_launch();
        int s0;
        do_reset();
        engine_ready = 1'b1;
        s0 = n_start;
        feed(100, 0, 0, 0);
        report(11'd40);
        sb.push_back('{byp: 1'b0, st: 1'b1, tau: 11'd40});
        feed(W - 100, 0, 0, 0);
        begin
            exp_t e = sb.pop_front();
            n_cmp++; if (bypass !== e.byp) begin n_bad++; $display("FAIL launch_bypass got %0b want %0b", bypass, e.byp); end
            n_cmp++; if (engine_start !== e.st) begin n_bad++; $display("FAIL launch_start got %0b want %0b", engine_start, e.st); end
            n_cmp++; if (engine_tau !== e.tau) begin n_bad++; $display("FAIL launch_tau got %0d want %0d", engine_tau, e.tau); end
        end
        repeat (30) step();
        n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL start_len got %0d want 1", n_start - s0); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL run_busy got %0b want 1", busy); end
        pulse_done();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL done_busy got %0b want 0", busy); end
        n_cmp++; if (engine_tau !== 11'd40) begin n_bad++; $display("FAIL tau_hold got %0d want 40", engine_tau); end
    endtask

    task automatic test_stale();
        do_reset();
        engine_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            sb.push_back('{byp: (w == 3), st: (w < 3), tau: 11'd40});
            if (w == 0) begin
                feed(10, 0, 0, 0);
                report(11'd40);
                feed(W - 10, 0, 0, 0);
            end else begin
                feed(W, 0, 0, 0);
            end
            begin
                exp_t e = sb.pop_front();
                n_cmp++; if (bypass !== e.byp) begin n_bad++; $display("FAIL stale%0d_bypass got %0b want %0b", w, bypass, e.byp); end
                n_cmp++; if (engine_start !== e.st) begin n_bad++; $display("FAIL stale%0d_start got %0b want %0b", w, engine_start, e.st); end
                n_cmp++; if (engine_tau !== e.tau) begin n_bad++; $display("FAIL stale%0d_tau got %0d want %0d", w, engine_tau, e.tau); end
            end
            step();
            pulse_done();
        end
    endtask

    task automatic test_tau_filter();
        logic [10:0] r1 [4];
        logic [10:0] r2 [4];
        logic [10:0] r3 [4];
        logic [10:0] want [4];
        r1 = '{11'd8, 11'd20, 11'd16, 11'd64};
        r2 = '{11'd2000, 11'd30, 11'd65, 11'd15};
        r3 = '{11'd60, 11'd0, 11'd0, 11'd0};
        want = '{11'd60, 11'd30, 11'd16, 11'd64};
        do_reset();
        engine_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            feed(10, 0, 0, 0);
            report(r1[w]);
            report(r2[w]);
            if (r3[w] != 11'd0) report(r3[w]);
            sb.push_back('{byp: 1'b0, st: 1'b1, tau: want[w]});
            feed(W - 10, 0, 0, 0);
            begin
                exp_t e = sb.pop_front();
                n_cmp++; if (engine_tau !== e.tau) begin n_bad++; $display("FAIL filter%0d_tau got %0d want %0d", w, engine_tau, e.tau); end
                n_cmp++; if (bypass !== e.byp) begin n_bad++; $display("FAIL filter%0d_bypass got %0b want %0b", w, bypass, e.byp); end
            end
            step();
            pulse_done();
        end
    endtask

    task automatic test_issue_overrun();
        do_reset();
        engine_ready = 1'b0;
        report(11'd40);
        feed(W, 0, 0, 0);
        report(11'd50);
        sb.push_back('{byp: 1'b0, st: 1'b1, tau: 11'd50});
        feed(W, 0, 0, 0);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL iss_ovr got %0b want 1", overrun); end
        n_cmp++; if (ovr_cnt !== 8'd1) begin n_bad++; $display("FAIL iss_cnt got %0d want 1", ovr_cnt); end
        begin
            exp_t e = sb.pop_front();
            n_cmp++; if (engine_tau !== e.tau) begin n_bad++; $display("FAIL iss_tau got %0d want %0d", engine_tau, e.tau); end
            n_cmp++; if (engine_start !== e.st) begin n_bad++; $display("FAIL iss_start got %0b want %0b", engine_start, e.st); end
            n_cmp++; if (bypass !== e.byp) begin n_bad++; $display("FAIL iss_bypass got %0b want %0b", bypass, e.byp); end
        end
    endtask

    task automatic test_run_overrun();
        int o0;
        do_reset();
        engine_ready = 1'b1;
        report(11'd40);
        feed(W, 0, 0, 0);
        step();
        o0 = n_ovr;
        for (int w = 0; w < 2; w++) begin
            sb.push_back('{byp: 1'b1, st: 1'b0, tau: 11'd40});
            feed(W, 0, 0, 0);
            begin
                exp_t e = sb.pop_front();
                n_cmp++; if (bypass !== e.byp) begin n_bad++; $display("FAIL run%0d_bypass got %0b want %0b", w, bypass, e.byp); end
                n_cmp++; if (engine_start !== e.st) begin n_bad++; $display("FAIL run%0d_start got %0b want %0b", w, engine_start, e.st); end
                n_cmp++; if (engine_tau !== e.tau) begin n_bad++; $display("FAIL run%0d_tau got %0d want %0d", w, engine_tau, e.tau); end
            end
        end
        step();
        n_cmp++; if (n_ovr - o0 !== 2) begin n_bad++; $display("FAIL run_pulses got %0d want 2", n_ovr - o0); end
        n_cmp++; if (ovr_cnt !== 8'd2) begin n_bad++; $display("FAIL run_cnt got %0d want 2", ovr_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL run_busy got %0b want 1", busy); end
        repeat (256) feed(W, 0, 0, 0);
        step();
        n_cmp++; if (ovr_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_cnt got %0d want 255", ovr_cnt); end
        n_cmp++; if (n_ovr - o0 !== 258) begin n_bad++; $display("FAIL sat_pulses got %0d want 258", n_ovr - o0); end
    endtask

    task automatic test_done_on_boundary();
        int o0;
        do_reset();
        engine_ready = 1'b1;
        report(11'd40);
        feed(W, 0, 0, 0);
        step();
        o0 = n_ovr;
        feed(W - 1, 0, 0, 0);
        sb.push_back('{byp: 1'b0, st: 1'b1, tau: 11'd40});
        feed(1, 1'b1, 11'd33, 1'b1);
        n_cmp++; if (boundary !== 1'b1) begin n_bad++; $display("FAIL db_bnd got %0b want 1", boundary); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL db_ovr got %0b want 0", overrun); end
        begin
            exp_t e = sb.pop_front();
            n_cmp++; if (engine_start !== e.st) begin n_bad++; $display("FAIL db_start got %0b want %0b", engine_start, e.st); end
            n_cmp++; if (engine_tau !== e.tau) begin n_bad++; $display("FAIL db_tau got %0d want %0d", engine_tau, e.tau); end
            n_cmp++; if (bypass !== e.byp) begin n_bad++; $display("FAIL db_bypass got %0b want %0b", bypass, e.byp); end
        end
        step();
        pulse_done();
        sb.push_back('{byp: 1'b0, st: 1'b1, tau: 11'd33});
        feed(W, 0, 0, 0);
        begin
            exp_t e = sb.pop_front();
            n_cmp++; if (engine_tau !== e.tau) begin n_bad++; $display("FAIL db_next_tau got %0d want %0d", engine_tau, e.tau); end
        end
        step();
        n_cmp++; if (n_ovr - o0 !== 0) begin n_bad++; $display("FAIL db_pulses got %0d want 0", n_ovr - o0); end
        n_cmp++; if (ovr_cnt !== 8'd0) begin n_bad++; $display("FAIL db_cnt got %0d want 0", ovr_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        sample_valid = 0; tau_valid = 0; tau_in = '0;
        engine_ready = 0; engine_done = 0;
        test_reset();
        test_first_window();
        test_job_launch();
        test_stale();
        test_tau_filter();
        test_issue_overrun();
        test_run_overrun();
        test_done_on_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
